store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of store entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port push_valid  input  1  producer offers an aligned store.
REQ-005 SHALL have port push_ready  output  1  buffer accepts the offered store this cycle.
REQ-006 SHALL have port push_addr  input  32  byte address of the store; only bits [31:2] are stored.
REQ-007 SHALL have port push_wdata  input  32  lane-aligned store data.
REQ-008 SHALL have port push_wmask  input  4  byte-lane write mask.
REQ-009 SHALL have port mem_valid  output  1  head entry is presented to memory.
REQ-010 SHALL have port mem_ready  input  1  memory accepts the head entry.
REQ-011 SHALL have port mem_addr  output  32  head word address, {addr[31:2], 2'b00}.
REQ-012 SHALL have port mem_wdata  output  32  head data.
REQ-013 SHALL have port mem_wstrb  output  4  head byte mask.
REQ-014 SHALL have port ld_addr  input  32  address of a pending load, for hazard check.
REQ-015 SHALL have port ld_hazard  output  1  pending load overlaps a buffered store.
REQ-016 SHALL have port empty  output  1  no entries held, used by fence/AMO drain logic.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of entries held.

Function
REQ-018 SHALL be a circular FIFO: write pointer, read pointer, occupancy counter; pointers wrap modulo DEPTH.
REQ-019 SHALL drive push_ready = (count != DEPTH), independent of mem_ready in the same cycle.
REQ-020 SHALL accept a push when push_valid && push_ready; the entry is written at the write pointer and the write pointer advances.
REQ-021 SHALL discard a push whose push_wmask == 4'b0000: handshake completes, nothing stored, count unchanged.
REQ-022 SHALL ignore push_valid while full; no state change, no data loss elsewhere.
REQ-023 SHALL drive mem_valid = (count != 0); mem_addr/mem_wdata/mem_wstrb come from the entry at the read pointer.
REQ-024 SHALL present a store pushed into an empty buffer in cycle N as mem_valid=1 in cycle N+1; there is no same-cycle bypass.
REQ-025 SHALL hold mem_valid and all mem_* outputs stable from assertion until the cycle mem_ready=1.
REQ-026 SHALL pop the head (read pointer advances, count decrements) when mem_valid && mem_ready.
REQ-027 SHALL, on simultaneous accepted push and pop, leave count unchanged and update both pointers.
REQ-028 SHALL ignore mem_ready while mem_valid=0.
REQ-029 SHALL preserve program order: memory sees stores in exact push order.
REQ-030 SHALL drive ld_hazard combinationally high iff any held entry, including the head being presented, has addr[31:2] == ld_addr[31:2] (word-granular and conservative, mask ignored).
REQ-031 SHALL drive empty = (count == 0).

Reset
REQ-032 SHALL on rst=1 at a clock edge clear pointers and count; mem_valid=0, empty=1, count=0, push_ready=1, ld_hazard=0 from the next cycle.
REQ-033 SHALL abandon an in-flight head on reset mid-transaction; mem_valid drops the cycle after the reset edge regardless of mem_ready.
REQ-034 SHALL leave entry storage uninitialised on reset; mem_addr/mem_wdata/mem_wstrb are don't-care while mem_valid=0.

Verification
REQ-035 SHALL cover single store: push addr 0x8000_0005, wdata 0x0000_AB00, wmask 0010 in cycle 0, mem_ready=1 -> cycle 1 mem_valid=1, mem_addr 0x8000_0004, mem_wstrb 0010; cycle 2 empty=1.
REQ-036 SHALL cover fill/backpressure: mem_ready=0, push 5 stores with DEPTH=4 -> push_ready=0 after 4th, 5th stalls, count=4; raise mem_ready -> drained in order, then 5th accepted.
REQ-037 SHALL cover simultaneous push/pop at count=2 -> count stays 2, order preserved.
REQ-038 SHALL cover hazard: buffer holds store to 0x1000_0010; ld_addr 0x1000_0013 -> ld_hazard=1; ld_addr 0x1000_0014 -> 0; after pop -> 0.
REQ-039 SHALL cover zero-mask push: wmask 0000 with push_valid=1 -> push_ready=1, count unchanged, no mem_valid.
REQ-040 SHALL cover reset with 3 entries and mem_valid=1, mem_ready=0 -> next cycle count=0, mem_valid=0, push_ready=1.

Source files
------------

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order circular store buffer that drains word-aligned stores to memory
// and flags pending loads that hit any buffered word.
module store_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [31:0]              push_addr,
    input  logic [31:0]              push_wdata,
    input  logic [3:0]               push_wmask,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic [31:0]              ld_addr,
    output logic                     ld_hazard,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:2]   addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_acc, pop_do;
    logic          unused_bits;
    assign unused_bits = ^{push_addr[1:0], ld_addr[1:0]};
    assign push_ready = cnt != CW'(DEPTH);
    // Zero-mask stores complete the handshake but are never stored
    assign push_acc   = push_valid && push_ready && (push_wmask != 4'b0000);
    assign mem_valid  = cnt != '0;
    assign pop_do     = mem_valid && mem_ready;
    assign mem_addr   = {addr_q[rd_ptr], 2'b00};
    assign mem_wdata  = data_q[rd_ptr];
    assign mem_wstrb  = mask_q[rd_ptr];
    assign empty      = cnt == '0;
    assign count      = cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_do) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push_acc) - CW'(pop_do);
        end
    end
    always_ff @(posedge clk) begin
        if (push_acc) begin
            addr_q[wr_ptr] <= push_addr[31:2];
            data_q[wr_ptr] <= push_wdata;
            mask_q[wr_ptr] <= push_wmask;
        end
    end
    // An entry is live when its distance from the read pointer is below the occupancy
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ({1'b0, AW'(i) - rd_ptr} < cnt && addr_q[i] == ld_addr[31:2]) ld_hazard = 1'b1;
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed scenarios plus randomized traffic against a queue model.
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    logic        clk = 0, rst = 1;
    logic        push_valid = 0, push_ready, mem_valid, mem_ready = 0, ld_hazard, empty;
    logic [31:0] push_addr = 0, push_wdata = 0, mem_addr, mem_wdata, ld_addr = 0;
    logic [3:0]  push_wmask = 0, mem_wstrb;
    logic [$clog2(DEPTH):0] count;
    int checks = 0, errors = 0;

    typedef struct { logic [31:0] a; logic [31:0] d; logic [3:0] m; } ent_t;
    ent_t q[$];

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_wdata(push_wdata), .push_wmask(push_wmask),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .ld_addr(ld_addr),
        .ld_hazard(ld_hazard), .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        bit hz = 0;
        foreach (q[i]) if (q[i].a[31:2] == ld_addr[31:2]) hz = 1;
        chk("push_ready", 32'(push_ready), 32'(q.size() != DEPTH));
        chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("count", 32'(count), 32'(q.size()));
        chk("ld_hazard", 32'(ld_hazard), 32'(hz));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, {q[0].a[31:2], 2'b00});
            chk("mem_wdata", mem_wdata, q[0].d);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(q[0].m));
        end
    endtask

    // Check settled outputs, then clock once and advance the model with the same inputs
    task automatic step();
        bit full;
        #1 check_model();
        @(posedge clk);
        full = q.size() == DEPTH;
        if (rst) q.delete();
        else begin
            if (q.size() != 0 && mem_ready) void'(q.pop_front());
            if (push_valid && !full && push_wmask != 0) q.push_back('{push_addr, push_wdata, push_wmask});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        push_valid = v; push_addr = a; push_wdata = d; push_wmask = m;
    endtask

    initial begin
        @(negedge clk);
        step();
        rst = 0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ready", 32'(push_ready), 1);
        chk("rst_mvalid", 32'(mem_valid), 0);

        // single store
        drive(1, 32'h8000_0005, 32'h0000_AB00, 4'b0010);
        mem_ready = 1;
        step();
        drive(0, 0, 0, 0);
        #1;
        chk("single_valid", 32'(mem_valid), 1);
        chk("single_addr", mem_addr, 32'h8000_0004);
        chk("single_wstrb", 32'(mem_wstrb), 32'h2);
        step();
        chk("single_empty", 32'(empty), 1);

        // fill and backpressure
        mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h2000_0000 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF);
            step();
        end
        drive(1, 32'h2000_0010, 32'hA4, 4'hF);
        #1;
        chk("fill_ready", 32'(push_ready), 0);
        step();
        chk("fill_count", 32'(count), 4);
        mem_ready = 1;
        step();
        step();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("fill_drained", 32'(empty), 1);

        // simultaneous push and pop at count 2
        mem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h3000_0000 + 32'(i * 4), 32'hB0 + 32'(i), 4'h3);
            step();
        end
        drive(1, 32'h3000_0008, 32'hB2, 4'hC);
        mem_ready = 1;
        step();
        chk("pushpop_count", 32'(count), 2);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        // load hazard
        mem_ready = 0;
        drive(1, 32'h1000_0010, 32'h1234_5678, 4'hF);
        step();
        drive(0, 0, 0, 0);
        ld_addr = 32'h1000_0013;
        #1 chk("hz_hit", 32'(ld_hazard), 1);
        ld_addr = 32'h1000_0014;
        #1 chk("hz_miss", 32'(ld_hazard), 0);
        ld_addr = 32'h1000_0010;
        mem_ready = 1;
        step();
        chk("hz_after_pop", 32'(ld_hazard), 0);

        // zero-mask push
        mem_ready = 0;
        drive(1, 32'h4000_0000, 32'hFFFF_FFFF, 4'h0);
        #1 chk("zm_ready", 32'(push_ready), 1);
        step();
        chk("zm_count", 32'(count), 0);
        chk("zm_mvalid", 32'(mem_valid), 0);

        // reset mid-transaction
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h5000_0000 + 32'(i * 4), 32'hC0 + 32'(i), 4'h1);
            step();
        end
        drive(0, 0, 0, 0);
        ld_addr = 32'h5000_0000;
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("rst3_count", 32'(count), 0);
        chk("rst3_mvalid", 32'(mem_valid), 0);
        chk("rst3_ready", 32'(push_ready), 1);
        chk("rst3_hazard", 32'(ld_hazard), 0);

        // randomized traffic over a small address window so hazards recur
        for (int n = 0; n < 3000; n++) begin
            rst = $urandom_range(0, 199) == 0;
            drive($urandom_range(0, 2) != 0, 32'h6000_0000 + $urandom_range(0, 31),
                  $urandom, $urandom_range(0, 5) == 0 ? 4'h0 : 4'($urandom));
            mem_ready = $urandom_range(0, 2) != 0;
            ld_addr = 32'h6000_0000 + $urandom_range(0, 31);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
